// File: rtl/snd_cmd_latch.sv
// snd_cmd_latch: Z80-side receiver of the 68k sound command channel (code latch, IRQ, status).
// Define SND_CMD_FIFO_EN to queue up to FIFO_DEPTH commands instead of holding a single byte.
module snd_cmd_latch #(
    parameter logic [15:0] CMD_ADDR   = 16'hA000,
    parameter logic [15:0] STAT_ADDR  = 16'hA001,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_main,
    input  logic        nRESET,
    input  logic        SNDDT,
    input  logic        SNDON,
    input  logic [7:0]  CPU_DIN,
    input  logic [15:0] Z80_ADDR,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nM1,
    output logic [7:0]  Z80_DOUT,
    output logic        Z80_OE,
    output logic        nINT,
    output logic        CMD_PENDING
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("snd_cmd_latch: FIFO_DEPTH must be a power of 2 in 2..16");
    end

    // ------------------------------------------------------------------
    // Input sampling and edge detection
    // ------------------------------------------------------------------
    logic       snddt_q;
    logic       sndon_q;
    logic       cmd_rd_q;
    logic       int_q, int_d;
    logic [7:0] shadow_q, shadow_d;

    logic       commit;
    logic       sndon_rise;
    logic       int_ack;
    logic       bus_rd;
    logic       rd_cmd;
    logic       rd_stat;
    logic       rd_end;

    assign commit     = !snddt_q && SNDDT;
    assign sndon_rise = !sndon_q && SNDON;
    assign int_ack    = !nM1 && !nIORQ;
    assign bus_rd     = !nMREQ && !nRD && nM1;
    assign rd_cmd     = bus_rd && (Z80_ADDR == CMD_ADDR);
    assign rd_stat    = bus_rd && (Z80_ADDR == STAT_ADDR);
    // The command read is consumed when nRD goes back high, not when it starts.
    assign rd_end     = cmd_rd_q && nRD;

    // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
    always_comb begin
        shadow_d = shadow_q;
        int_d    = int_q;
        if (!SNDDT) begin
            shadow_d = CPU_DIN;
        end
        if (sndon_rise) begin
            int_d = 1'b1;
        end else if (int_ack) begin
            int_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments here so every register sees pre-edge values of the others.
    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            snddt_q  <= 1'b1;
            sndon_q  <= 1'b0;
            cmd_rd_q <= 1'b0;
            int_q    <= 1'b0;
            shadow_q <= 8'h00;
        end else begin
            snddt_q  <= SNDDT;
            sndon_q  <= SNDON;
            cmd_rd_q <= rd_cmd;
            int_q    <= int_d;
            shadow_q <= shadow_d;
        end
    end

    // ------------------------------------------------------------------
    // Command storage
    // ------------------------------------------------------------------
    logic       overrun_q, overrun_d;
    logic       pending_flag;
    logic       full_flag;
    logic [7:0] cmd_byte;

`ifdef SND_CMD_FIFO_EN
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty;
    logic        fifo_full;
    logic        do_pop;
    logic        do_push;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = rd_end && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign do_push    = commit && (!fifo_full || do_pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Overrun survives the drain; the read that finds the queue empty clears it.
        if (rd_end && fifo_empty) begin
            overrun_d = 1'b0;
        end else if (commit && !do_push) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the queue storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_main) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shadow_q;
        end
    end

    assign cmd_byte     = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign pending_flag = !fifo_empty;
    assign full_flag    = fifo_full;
`else
    logic [7:0] cmd_q, cmd_d;
    logic       pending_q, pending_d;

    // A commit always wins over a concurrent read-clear; the read still clears overrun.
    always_comb begin
        cmd_d     = cmd_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (commit) begin
            cmd_d     = shadow_q;
            pending_d = 1'b1;
            overrun_d = rd_end ? 1'b0 : (overrun_q || pending_q);
        end else if (rd_end) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            cmd_q     <= 8'h00;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign cmd_byte     = cmd_q;
    assign pending_flag = pending_q;
    assign full_flag    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Z80 read port and outputs
    // ------------------------------------------------------------------
    logic [7:0] status_byte;

    assign status_byte = {5'b0, full_flag, overrun_q, pending_flag};

    // Gated by reset so the bus is released immediately, even mid-read.
    assign Z80_OE      = nRESET && (rd_cmd || rd_stat);

    always_comb begin
        Z80_DOUT = 8'hFF;
        if (Z80_OE) begin
            Z80_DOUT = rd_cmd ? cmd_byte : status_byte;
        end
    end

    assign nINT        = !int_q;
    assign CMD_PENDING = pending_flag;

endmodule

// File: tb/tb_snd_cmd_latch.sv
// Self-checking bench for snd_cmd_latch: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the command channel.
module tb_snd_cmd_latch;

    localparam logic [15:0] CMD_ADDR  = 16'hA000;
    localparam logic [15:0] STAT_ADDR = 16'hA001;
    localparam int          DEPTH     = 4;

    logic        clk_main = 1'b0;
    logic        nRESET;
    logic        SNDDT;
    logic        SNDON;
    logic [7:0]  CPU_DIN;
    logic [15:0] Z80_ADDR;
    logic        nMREQ;
    logic        nIORQ;
    logic        nRD;
    logic        nM1;
    logic [7:0]  Z80_DOUT;
    logic        Z80_OE;
    logic        nINT;
    logic        CMD_PENDING;

    int n_tests = 0;
    int n_fail  = 0;

    snd_cmd_latch #(
        .CMD_ADDR  (CMD_ADDR),
        .STAT_ADDR (STAT_ADDR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_main   (clk_main),
        .nRESET     (nRESET),
        .SNDDT      (SNDDT),
        .SNDON      (SNDON),
        .CPU_DIN    (CPU_DIN),
        .Z80_ADDR   (Z80_ADDR),
        .nMREQ      (nMREQ),
        .nIORQ      (nIORQ),
        .nRD        (nRD),
        .nM1        (nM1),
        .Z80_DOUT   (Z80_DOUT),
        .Z80_OE     (Z80_OE),
        .nINT       (nINT),
        .CMD_PENDING(CMD_PENDING)
    );

    always #5 clk_main = ~clk_main;

    // ------------------------------------------------------------------
    // Reference model: commands as a queue of bytes, IRQ as a held flag
    // ------------------------------------------------------------------
    logic       m_prev_dt;
    logic       m_prev_on;
    logic       m_in_read;
    logic       m_irq;
    logic       m_ovr;
    logic       m_pend;
    logic [7:0] m_latched;
    logic [7:0] m_cmd;
    logic [7:0] m_q[$];

    task automatic model_reset();
        m_prev_dt = 1'b1;
        m_prev_on = 1'b0;
        m_in_read = 1'b0;
        m_irq     = 1'b0;
        m_ovr     = 1'b0;
        m_pend    = 1'b0;
        m_latched = 8'h00;
        m_cmd     = 8'h00;
        m_q.delete();
    endtask

    function automatic logic exp_pending();
`ifdef SND_CMD_FIFO_EN
        return m_q.size() != 0;
`else
        return m_pend;
`endif
    endfunction

    function automatic logic [7:0] exp_status();
        logic full;
`ifdef SND_CMD_FIFO_EN
        full = (m_q.size() == DEPTH);
`else
        full = 1'b0;
`endif
        return {5'b0, full, m_ovr, exp_pending()};
    endfunction

    function automatic logic [7:0] exp_cmd();
`ifdef SND_CMD_FIFO_EN
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
`else
        return m_cmd;
`endif
    endfunction

    task automatic model_step();
        logic wrote;
        logic rise;
        logic ack;
        logic read_done;
        wrote     = !m_prev_dt && SNDDT;
        rise      = !m_prev_on && SNDON;
        ack       = !nM1 && !nIORQ;
        read_done = m_in_read && nRD;
`ifdef SND_CMD_FIFO_EN
        if (read_done) begin
            if (m_q.size() == 0) m_ovr = 1'b0;
            else void'(m_q.pop_front());
        end
        if (wrote) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_latched);
            else m_ovr = 1'b1;
        end
`else
        if (wrote) begin
            if (read_done) m_ovr = 1'b0;
            else if (m_pend) m_ovr = 1'b1;
            m_cmd  = m_latched;
            m_pend = 1'b1;
        end else if (read_done) begin
            m_pend = 1'b0;
            m_ovr  = 1'b0;
        end
`endif
        if (rise) m_irq = 1'b1;
        else if (ack) m_irq = 1'b0;
        if (!SNDDT) m_latched = CPU_DIN;
        m_prev_dt = SNDDT;
        m_prev_on = SNDON;
        m_in_read = !nMREQ && !nRD && nM1 && (Z80_ADDR == CMD_ADDR);
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside)
    // ------------------------------------------------------------------
    task automatic tick();
        if (!nRESET) model_reset();
        else model_step();
        @(posedge clk_main);
        @(negedge clk_main);
    endtask

    task automatic z80_read(input logic [15:0] addr, output logic [7:0] data, output logic oe);
        Z80_ADDR = addr;
        nM1      = 1'b1;
        nMREQ    = 1'b0;
        nRD      = 1'b0;
        #1;
        data = Z80_DOUT;
        oe   = Z80_OE;
        tick();
        nRD   = 1'b1;
        nMREQ = 1'b1;
        tick();
    endtask

    task automatic sound_write(input logic [7:0] data);
        SNDDT   = 1'b0;
        CPU_DIN = data;
        repeat (3) tick();
        SNDDT = 1'b1;
        tick();
    endtask

    task automatic irq_ack();
        nM1   = 1'b0;
        nIORQ = 1'b0;
        tick();
        nM1   = 1'b1;
        nIORQ = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [7:0] d;
        logic       oe;
        nRESET = 1'b0;
        repeat (5) tick();
        nRESET = 1'b1;
        tick();
        n_tests++;
        if (nINT !== 1'b1) begin
            n_fail++; $display("FAIL reset_nint got %b exp 1", nINT);
        end
        n_tests++;
        if (CMD_PENDING !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending got %b exp 0", CMD_PENDING);
        end
        n_tests++;
        if (Z80_OE !== 1'b0 || Z80_DOUT !== 8'hFF) begin
            n_fail++; $display("FAIL reset_idle_bus got oe=%b dout=%h exp oe=0 dout=ff", Z80_OE, Z80_DOUT);
        end
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
        if (oe !== 1'b1 || d !== 8'h00) begin
            n_fail++; $display("FAIL reset_status got oe=%b d=%h exp oe=1 d=00", oe, d);
        end
    endtask

    task automatic test_capture_read();
        logic [7:0] d;
        logic       oe;
        SNDDT   = 1'b0;
        CPU_DIN = 8'h5A;
        repeat (3) tick();
        n_tests++;
        if (CMD_PENDING !== 1'b0) begin
            n_fail++; $display("FAIL capture_early_pending got %b exp 0", CMD_PENDING);
        end
        SNDDT = 1'b1;
        tick();
        n_tests++;
        if (CMD_PENDING !== 1'b1) begin
            n_fail++; $display("FAIL capture_pending got %b exp 1", CMD_PENDING);
        end
        SNDON = 1'b1;
        tick();
        n_tests++;
        if (nINT !== 1'b0) begin
            n_fail++; $display("FAIL irq_assert got %b exp 0", nINT);
        end
        tick();
        n_tests++;
        if (nINT !== 1'b0) begin
            n_fail++; $display("FAIL irq_hold got %b exp 0", nINT);
        end
        irq_ack();
        n_tests++;
        if (nINT !== 1'b1) begin
            n_fail++; $display("FAIL irq_ack_release got %b exp 1", nINT);
        end
        tick();
        n_tests++;
        if (nINT !== 1'b1) begin
            n_fail++; $display("FAIL irq_level_no_retrigger got %b exp 1", nINT);
        end
        z80_read(CMD_ADDR, d, oe);
        n_tests++;
        if (oe !== 1'b1 || d !== 8'h5A) begin
            n_fail++; $display("FAIL read_cmd got oe=%b d=%h exp oe=1 d=5a", oe, d);
        end
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h00 || CMD_PENDING !== 1'b0) begin
            n_fail++; $display("FAIL read_cleared got status=%h pending=%b exp 00/0", d, CMD_PENDING);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic       oe;
        sound_write(8'h11);
        sound_write(8'h22);
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h03) begin
            n_fail++; $display("FAIL overrun_status got %h exp 03", d);
        end
        z80_read(CMD_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h22) begin
            n_fail++; $display("FAIL overrun_cmd got %h exp 22", d);
        end
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL overrun_cleared got %h exp 00", d);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        logic       oe;
        SNDON = 1'b0;
        tick();
        SNDON = 1'b1;
        tick();
        SNDON = 1'b0;
        tick();
        SNDON = 1'b1;
        nM1   = 1'b0;
        nIORQ = 1'b0;
        tick();
        nM1   = 1'b1;
        nIORQ = 1'b1;
        n_tests++;
        if (nINT !== 1'b0) begin
            n_fail++; $display("FAIL rise_beats_ack got %b exp 0", nINT);
        end
        irq_ack();
        n_tests++;
        if (nINT !== 1'b1) begin
            n_fail++; $display("FAIL ack_after_rise got %b exp 1", nINT);
        end
        sound_write(8'h44);
        sound_write(8'h44);
        // Commit of 33 lands on the same edge as the end of a command read.
        SNDDT    = 1'b0;
        CPU_DIN  = 8'h33;
        Z80_ADDR = CMD_ADDR;
        nM1      = 1'b1;
        nMREQ    = 1'b0;
        nRD      = 1'b0;
        tick();
        SNDDT = 1'b1;
        nRD   = 1'b1;
        nMREQ = 1'b1;
        tick();
        n_tests++;
        if (CMD_PENDING !== 1'b1) begin
            n_fail++; $display("FAIL commit_beats_clear_pending got %b exp 1", CMD_PENDING);
        end
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
`ifdef SND_CMD_FIFO_EN
        if (d !== 8'h01) begin
            n_fail++; $display("FAIL commit_beats_clear_status got %h exp 01", d);
        end
        z80_read(CMD_ADDR, d, oe);
`else
        if (d !== 8'h01) begin
            n_fail++; $display("FAIL commit_beats_clear_status got %h exp 01", d);
        end
`endif
        z80_read(CMD_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h33) begin
            n_fail++; $display("FAIL commit_beats_clear_cmd got %h exp 33", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       oe;
        SNDON = 1'b0;
        tick();
        SNDON = 1'b1;
        tick();
        sound_write(8'h77);
        SNDDT   = 1'b0;
        CPU_DIN = 8'h99;
        tick();
        #2;
        nRESET = 1'b0;
        #1;
        n_tests++;
        if (nINT !== 1'b1 || CMD_PENDING !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got nint=%b pending=%b exp 1/0", nINT, CMD_PENDING);
        end
        SNDDT = 1'b1;
        SNDON = 1'b0;
        tick();
        tick();
        nRESET = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (CMD_PENDING !== 1'b0 || nINT !== 1'b1) begin
            n_fail++; $display("FAIL reset_discard got pending=%b nint=%b exp 0/1", CMD_PENDING, nINT);
        end
        z80_read(CMD_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL reset_cmd_value got %h exp 00", d);
        end
    endtask

`ifdef SND_CMD_FIFO_EN
    task automatic test_fifo();
        logic [7:0] d;
        logic       oe;
        for (int i = 1; i <= 5; i++) sound_write(8'(i));
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h07) begin
            n_fail++; $display("FAIL fifo_full_status got %h exp 07", d);
        end
        for (int i = 1; i <= 4; i++) begin
            z80_read(CMD_ADDR, d, oe);
            n_tests++;
            if (d !== 8'(i)) begin
                n_fail++; $display("FAIL fifo_pop_%0d got %h exp %h", i, d, 8'(i));
            end
        end
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h02) begin
            n_fail++; $display("FAIL fifo_drained_status got %h exp 02", d);
        end
        z80_read(CMD_ADDR, d, oe);
        z80_read(STAT_ADDR, d, oe);
        n_tests++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL fifo_overrun_clear got %h exp 00", d);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_d;
        logic       exp_oe;
        for (int i = 0; i < 600; i++) begin
            SNDDT   = ($urandom_range(0, 2) != 0);
            SNDON   = ($urandom_range(0, 3) == 0) ? ~SNDON : SNDON;
            CPU_DIN = 8'($urandom);
            nM1     = ($urandom_range(0, 7) != 0);
            nIORQ   = ($urandom_range(0, 5) != 0);
            nMREQ   = ($urandom_range(0, 3) == 0);
            nRD     = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 3))
                0, 1:    Z80_ADDR = CMD_ADDR;
                2:       Z80_ADDR = STAT_ADDR;
                default: Z80_ADDR = 16'($urandom);
            endcase
            nMREQ = ~nMREQ;
            #1;
            exp_oe = !nMREQ && !nRD && nM1 &&
                     (Z80_ADDR == CMD_ADDR || Z80_ADDR == STAT_ADDR);
            exp_d  = !exp_oe ? 8'hFF : (Z80_ADDR == CMD_ADDR) ? exp_cmd() : exp_status();
            n_tests++;
            if (Z80_OE !== exp_oe || Z80_DOUT !== exp_d) begin
                n_fail++;
                $display("FAIL rand_bus[%0d] got oe=%b d=%h exp oe=%b d=%h", i, Z80_OE, Z80_DOUT, exp_oe, exp_d);
            end
            tick();
            n_tests++;
            if (nINT !== !m_irq || CMD_PENDING !== exp_pending()) begin
                n_fail++;
                $display("FAIL rand_state[%0d] got nint=%b pend=%b exp nint=%b pend=%b", i, nINT, CMD_PENDING, !m_irq, exp_pending());
            end
        end
        SNDDT = 1'b1;
        nMREQ = 1'b1;
        nRD   = 1'b1;
        nM1   = 1'b1;
        nIORQ = 1'b1;
        tick();
    endtask

    initial begin
        nRESET   = 1'b0;
        SNDDT    = 1'b1;
        SNDON    = 1'b0;
        CPU_DIN  = 8'h00;
        Z80_ADDR = 16'h0000;
        nMREQ    = 1'b1;
        nIORQ    = 1'b1;
        nRD      = 1'b1;
        nM1      = 1'b1;
        model_reset();
        @(negedge clk_main);
        test_reset();
        test_capture_read();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
`ifdef SND_CMD_FIFO_EN
        test_fifo();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/snd_cmd_latch.md
Name: snd_cmd_latch

Overview:
Z80-side receiver of the 68k→sound-CPU command channel.
- Captures the 8-bit sound code written by the 68k through the SNDDT strobe.
- Converts SNDON rising edges into a held Z80 maskable interrupt.
- Presents the code and a status byte to Z80 memory reads.
- Sits on the sound board between the 68k I/O decode (SNDDT, SNDON) and the Z80 bus. All logic runs on clk_main.

Parameters:
- CMD_ADDR, 16'hA000, Z80 memory address of the command byte (read-only).
- STAT_ADDR, 16'hA001, Z80 memory address of the status byte (read-only).
- FIFO_DEPTH, 4, command queue depth; used only when SND_CMD_FIFO_EN is defined; must be a power of 2, range 2..16.

Ports:
- clk_main  in  1  system clock; every input is sampled on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- SNDDT  in  1  68k sound-code write strobe, active low.
- SNDON  in  1  68k Z80-IRQ trigger level (IOWR register bit 3).
- CPU_DIN  in  8  68k data bus, m68k_dout[7:0].
- Z80_ADDR  in  16  Z80 address bus.
- nMREQ  in  1  Z80 memory request.
- nIORQ  in  1  Z80 I/O request.
- nRD  in  1  Z80 read strobe.
- nM1  in  1  Z80 M1 cycle.
- Z80_DOUT  out  8  data driven to the Z80 when Z80_OE=1; 8'hFF otherwise.
- Z80_OE  out  1  this block is driving the Z80 data bus.
- nINT  out  1  Z80 interrupt request, active low.
- CMD_PENDING  out  1  an unread command exists (debug / status).

Behaviour:
- Reset (nRESET=0, asynchronous), all of the following apply immediately:
  - cmd register = 8'h00
  - CMD_PENDING = 0
  - nINT = 1
  - Z80_OE = 0
  - Z80_DOUT = 8'hFF
  - overrun flag = 0
  - edge-detect registers: snddt_q = 1, sndon_q = 0
  - A reset asserted mid-write or mid-acknowledge discards that operation. No command is captured on the first rising edge after release unless SNDDT is low → high within the new sampling window.
- Command capture:
  - While SNDDT=0, CPU_DIN is registered into a shadow register every cycle.
  - On a detected rising edge (snddt_q=0, SNDDT=1), the shadow is committed to cmd on that clock edge.
  - Committing sets CMD_PENDING=1, one cycle after the SNDDT rise.
  - If CMD_PENDING was already 1 at commit, the new value overwrites cmd and the overrun flag is set to 1.
  - A SNDDT low pulse shorter than one clock that is never sampled low is ignored.
- IRQ generation:
  - A rising edge of SNDON (sndon_q=0, SNDON=1) drives nINT low on the next clock.
  - nINT stays low (hold-line) until an acknowledge cycle is seen: nM1=0 and nIORQ=0 sampled together. nINT returns high on the clock after the first such sample.
  - A new SNDON rise in the same cycle as the acknowledge wins: nINT stays low.
  - SNDON held high produces no further IRQs.
  - No interrupt vector is driven; Z80_OE stays 0 during acknowledge (IM1 assumed by sound firmware).
- Z80 read (combinational decode, registered clear):
  - Condition: nMREQ=0, nRD=0, nM1=1, Z80_ADDR=CMD_ADDR → Z80_OE=1, Z80_DOUT=cmd.
  - Condition: same strobes, Z80_ADDR=STAT_ADDR → Z80_OE=1, Z80_DOUT = {6'b0, overrun, CMD_PENDING}.
  - A CMD_ADDR read clears CMD_PENDING and overrun on the clock where nRD rises (end of read, detected by edge register), not at the start.
  - A commit in the same cycle as the read-clear wins: CMD_PENDING stays 1, cmd takes the new value, overrun is cleared.
  - Opcode fetches (nM1=0) to either address do not clear anything.

Optional Feature:
- Macro: SND_CMD_FIFO_EN.
- Defined:
  - Commits push into a FIFO_DEPTH-entry circular queue (write pointer and read pointer, each log2(FIFO_DEPTH)+1 bits; wrap by MSB compare).
  - CMD_ADDR returns the head entry; the end of a CMD_ADDR read pops it.
  - CMD_PENDING = not empty.
  - A push when full drops the new byte and sets overrun; the queue contents are unchanged.
  - Simultaneous push and pop when full succeeds for both; count is unchanged.
  - Status bit 2 = full.
  - Reset empties the queue.
- Undefined: single-register behaviour as above; status bit 2 = 0.

Test Plan:
- Reset: hold nRESET=0 for 5 clocks, then release → nINT=1, CMD_PENDING=0, status read at 16'hA001 returns 8'h00, Z80_OE=0 when idle.
- Capture and read:
  - Stimulus: SNDDT low 3 clocks with CPU_DIN=8'h5A, then high; SNDON 0→1.
  - Expect: CMD_PENDING=1 one clock after the SNDDT rise; nINT low one clock after the SNDON rise.
  - Then: Z80 ack (nM1=0, nIORQ=0) → nINT=1 next clock.
  - Then: read 16'hA000 → 8'h5A; status afterwards = 8'h00.
- Overrun: write 8'h11 then 8'h22 with no Z80 read → status = 8'h03, read 16'hA000 returns 8'h22, status then = 8'h00.
- Simultaneous events:
  - SNDON rise in the same clock as the ack sample → nINT stays 0.
  - SNDDT commit of 8'h33 in the same clock as a read-clear → CMD_PENDING=1, cmd=8'h33.
- Reset mid-operation: assert nRESET while SNDDT=0 and nINT=0 → nINT=1 and CMD_PENDING=0 with no clock edge; no command is committed after release.
- FIFO (SND_CMD_FIFO_EN, FIFO_DEPTH=4):
  - Push 8'h01..8'h05 → status = 8'h07, the 5th byte is dropped.
  - Four reads return 01, 02, 03, 04; status then = 8'h02 (overrun still set until cleared by the next read).
